// File: rtl/mcpu_regfile_wb_ctrl.sv
// Register-file write-back controller: round-robin arbitration between the ALU and
// load write-back ports, plus a sequencer that clears every register one per cycle.
module mcpu_regfile_wb_ctrl #(
  parameter int WORD_SIZE         = 16,
  parameter int REGS_NUMBER_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_req,
  output logic                         clr_busy,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REGS_NUMBER_WIDTH-1:0] alu_reg,
  input  logic [WORD_SIZE-1:0]         alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [REGS_NUMBER_WIDTH-1:0] ld_reg,
  input  logic [WORD_SIZE-1:0]         ld_data,
  output logic [REGS_NUMBER_WIDTH-1:0] rf_op1,
  output logic [WORD_SIZE-1:0]         rf_datatoload,
  output logic [1:0]                   rf_regsetcmd,
  output logic                         rf_regsetwb
);

  localparam int REGISTERS_NUMBER = 1 << REGS_NUMBER_WIDTH;
  localparam logic [REGS_NUMBER_WIDTH-1:0] LAST_INDEX = REGS_NUMBER_WIDTH'(REGISTERS_NUMBER - 1);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state;
  logic [REGS_NUMBER_WIDTH-1:0]   clr_index;
  logic                           last_ld;
  logic                           idle_free;
  logic                           clr_accept;
  logic                           grant_alu;
  logic                           grant_ld;

  // Grants are combinational; rst_n gating keeps them low while reset is asserted.
  always_comb begin
    idle_free  = rst_n && (state == IDLE) && !clr_req;
    clr_accept = rst_n && (state == IDLE) && clr_req;
    grant_alu  = idle_free && alu_valid && (!ld_valid || last_ld);
    grant_ld   = idle_free && ld_valid && (!alu_valid || !last_ld);
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;
  assign clr_busy  = clr_accept || (rst_n && (state == CLEAR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      clr_index     <= '0;
      last_ld       <= 1'b1;
      rf_regsetwb   <= 1'b0;
      rf_regsetcmd  <= CMD_WRITE;
      rf_op1        <= '0;
      rf_datatoload <= '0;
    end else begin
      rf_regsetwb <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state     <= CLEAR;
            clr_index <= '0;
          end else if (grant_alu) begin
            rf_regsetwb   <= 1'b1;
            rf_regsetcmd  <= CMD_WRITE;
            rf_op1        <= alu_reg;
            rf_datatoload <= alu_data;
            last_ld       <= 1'b0;
          end else if (grant_ld) begin
            rf_regsetwb   <= 1'b1;
            rf_regsetcmd  <= CMD_WRITE;
            rf_op1        <= ld_reg;
            rf_datatoload <= ld_data;
            last_ld       <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_req is deliberately ignored here: no restart, no queuing.
          rf_regsetwb  <= 1'b1;
          rf_regsetcmd <= CMD_CLEAR;
          rf_op1       <= clr_index;
          clr_index    <= clr_index + 1'b1;
          if (clr_index == LAST_INDEX) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
